// File: rtl/neuron_multi_level_input.sv
// Multi-level input driver: loads one vector of {sign, count} bytes, then replays it as
// positive/negative bit-planes over the SPI write path with one inference pulse per plane.
module neuron_multi_level_input #(
    parameter int spi_length = 576,
    parameter int cnt_width  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_trigger,
    output logic                  idle,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [spi_length-1:0] spi_output,
    output logic                  spi_write_trigger,
    input  logic                  spi_idle,
    output logic                  pulse_trigger,
    output logic                  pulse_sign,
    input  logic                  neuron_idle
);

    // Four element bytes arrive per 32-bit word.
    localparam int n_words = spi_length / 4;
    localparam int word_w  = $clog2(n_words);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER_CHECK,
        ST_PLANE,
        ST_SPI_TRIG,
        ST_SPI_WAIT,
        ST_PULSE_TRIG,
        ST_PULSE_WAIT,
        ST_NEXT_ITER
    } state_e;

    typedef enum logic {
        PH_POS = 1'b0,
        PH_NEG = 1'b1
    } phase_e;

    state_e                 state_q, state_d;
    phase_e                 phase_q, phase_d;
    logic [word_w-1:0]      word_cnt_q, word_cnt_d;
    logic [cnt_width-1:0]   max_cnt_q, max_cnt_d;
    logic [cnt_width-1:0]   iter_q, iter_d;
    logic [1:0]             trig_cnt_q, trig_cnt_d;

    logic [cnt_width-1:0]   cnt_q [spi_length];
    logic [spi_length-1:0]  sign_q;

    logic                   idle_q, in_ready_q, spi_trig_q, pulse_trig_q, pulse_sign_q;
    logic [spi_length-1:0]  spi_output_q;

    logic                   load_word;
    logic [cnt_width-1:0]   word_max;
    logic [spi_length-1:0]  plane_d;
    logic                   neg_phase;

    assign neg_phase = (phase_q == PH_NEG);

    always_comb begin
        word_max = '0;
        for (int j = 0; j < 4; j++) begin
            if (in_data[8*j +: cnt_width] > word_max) begin
                word_max = in_data[8*j +: cnt_width];
            end
        end
    end

    // Count 0 can never exceed iter, so empty elements are never driven.
    always_comb begin
        plane_d = '0;
        for (int e = 0; e < spi_length; e++) begin
            plane_d[e] = (cnt_q[e] > iter_q) && (sign_q[e] == neg_phase);
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        phase_d    = phase_q;
        word_cnt_d = word_cnt_q;
        max_cnt_d  = max_cnt_q;
        iter_d     = iter_q;
        trig_cnt_d = trig_cnt_q;
        load_word  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (input_trigger) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = '0;
                    max_cnt_d  = '0;
                    iter_d     = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    load_word  = 1'b1;
                    word_cnt_d = word_cnt_q + word_w'(1);
                    if (word_max > max_cnt_q) begin
                        max_cnt_d = word_max;
                    end
                    if (word_cnt_q == word_w'(n_words - 1)) begin
                        state_d = ST_ITER_CHECK;
                    end
                end
            end
            ST_ITER_CHECK: begin
                if (iter_q == max_cnt_q) begin
                    state_d = ST_IDLE;
                end else begin
                    phase_d = PH_POS;
                    state_d = ST_PLANE;
                end
            end
            ST_PLANE: begin
                // An empty negative plane carries no work; the positive plane keeps the pulse cadence.
                if (neg_phase && !(|plane_d)) begin
                    state_d = ST_NEXT_ITER;
                end else begin
                    trig_cnt_d = '0;
                    state_d    = ST_SPI_TRIG;
                end
            end
            ST_SPI_TRIG: begin
                trig_cnt_d = trig_cnt_q + 2'd1;
                if (trig_cnt_q == 2'd3) begin
                    state_d = ST_SPI_WAIT;
                end
            end
            ST_SPI_WAIT: begin
                if (spi_idle) begin
                    trig_cnt_d = '0;
                    state_d    = ST_PULSE_TRIG;
                end
            end
            ST_PULSE_TRIG: begin
                trig_cnt_d = trig_cnt_q + 2'd1;
                if (trig_cnt_q == 2'd3) begin
                    state_d = ST_PULSE_WAIT;
                end
            end
            ST_PULSE_WAIT: begin
                if (neuron_idle) begin
                    if (neg_phase) begin
                        state_d = ST_NEXT_ITER;
                    end else begin
                        phase_d = PH_NEG;
                        state_d = ST_PLANE;
                    end
                end
            end
            ST_NEXT_ITER: begin
                iter_d  = iter_q + cnt_width'(1);
                state_d = ST_ITER_CHECK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_POS;
            word_cnt_q   <= '0;
            max_cnt_q    <= '0;
            iter_q       <= '0;
            trig_cnt_q   <= '0;
            idle_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            spi_trig_q   <= 1'b0;
            pulse_trig_q <= 1'b0;
            pulse_sign_q <= 1'b0;
            spi_output_q <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            word_cnt_q   <= word_cnt_d;
            max_cnt_q    <= max_cnt_d;
            iter_q       <= iter_d;
            trig_cnt_q   <= trig_cnt_d;
            idle_q       <= (state_d == ST_IDLE);
            in_ready_q   <= (state_d == ST_LOAD);
            spi_trig_q   <= (state_d == ST_SPI_TRIG);
            pulse_trig_q <= (state_d == ST_PULSE_TRIG);
            if (state_d == ST_PULSE_TRIG) begin
                pulse_sign_q <= neg_phase;
            end
            if (state_q == ST_PLANE) begin
                spi_output_q <= plane_d;
            end
        end
    end

    // NOTE: the element store is reset explicitly so a vector never inherits stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < spi_length; e++) begin
                cnt_q[e] <= '0;
            end
            sign_q <= '0;
        end else if (load_word) begin
            for (int j = 0; j < 4; j++) begin
                cnt_q[{word_cnt_q, j[1:0]}]  <= in_data[8*j +: cnt_width];
                sign_q[{word_cnt_q, j[1:0]}] <= in_data[8*j + 7];
            end
        end
    end

    assign idle              = idle_q;
    assign in_ready          = in_ready_q;
    assign spi_output        = spi_output_q;
    assign spi_write_trigger = spi_trig_q;
    assign pulse_trigger     = pulse_trig_q;
    assign pulse_sign        = pulse_sign_q;

endmodule
